sram_ctrl: RTL and testbench

Single-port synchronous SRAM initiator for the GMM background-model store. It accepts burst read/write requests from the pixel pipeline and drives the SRAM's active-low chip-enable, write-enable and output-enable strobes. It owns the shared tristate data bus and the SRAM address. Bursts use auto-incrementing addresses at one word per cycle, with a guaranteed bus-turnaround gap.

---
 rtl/sram_ctrl.sv | 137 +++++++++++++
 tb/tb_sram_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl
//   Burst initiator for the single-port synchronous SRAM that holds the GMM
//   background model. Accepts read/write bursts from the pixel pipeline,
//   generates registered active-low strobes, owns the tristate data bus and
//   inserts a one-cycle all-high turnaround after every burst.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       burst request handshake
//   req_we, req_addr, req_len burst direction, start address, length-1
//   wdata_valid/wdata_ready   write word handshake, wdata = write word
//   rsp_valid, rsp_rdata      read word pulse (no backpressure)
//   busy                      burst or turnaround in progress
//   sram_addr, sram_data      SRAM address (registered) and shared data bus
//   sram_ce_n/we_n/oe_n       registered active-low SRAM strobes
module sram_ctrl #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] TURN  = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic              drain;
  logic              drive_en;
  logic [DATA_W-1:0] drive_data;
  logic              issue_wr;
  logic              issue_rd;

  assign req_ready   = (state == IDLE) && !rst;
  assign busy        = (state != IDLE);
  assign wdata_ready = (state == WRITE) && !drain && !rst;

  // The bus is only driven while a write strobe is on the SRAM pins.
  assign sram_data = drive_en ? drive_data : {DATA_W{1'bz}};

  // drain marks the cycle in which the final strobe of a burst sits on the
  // pins; no new word may be issued then, and the following edge enters TURN.
  assign issue_wr = (state == WRITE) && !drain && wdata_valid;
  assign issue_rd = (state == READ) && !drain;

  // Strobes default high each cycle and are pulled low only for an issued
  // word, so a write gap or the post-burst cycle can never strobe twice.
  // Read data is captured at the closing edge of its strobe cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      len_q      <= '0;
      cnt        <= '0;
      drain      <= 1'b0;
      drive_en   <= 1'b0;
      drive_data <= '0;
      sram_addr  <= '0;
      sram_ce_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      sram_ce_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      drive_en  <= 1'b0;
      rsp_valid <= !sram_ce_n && !sram_oe_n;
      if (!sram_ce_n && !sram_oe_n) begin
        rsp_rdata <= sram_data;
      end

      case (state)
        IDLE: begin
          if (req_valid) begin
            cur_addr <= req_addr;
            len_q    <= req_len;
            cnt      <= '0;
            drain    <= 1'b0;
            state    <= req_we ? WRITE : READ;
          end
        end
        WRITE, READ: begin
          if (drain) begin
            drain <= 1'b0;
            state <= TURN;
          end else if (issue_wr || issue_rd) begin
            sram_addr <= cur_addr;
            sram_ce_n <= 1'b0;
            sram_we_n <= !issue_wr;
            sram_oe_n <= issue_wr;
            drive_en  <= issue_wr;
            if (issue_wr) begin
              drive_data <= wdata;
            end
            cur_addr <= cur_addr + 1'b1;
            if (cnt == len_q) begin
              drain <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        TURN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl
//   Directed bench for sram_ctrl with a small behavioural SRAM (64 words,
//   indexed by the low address bits) attached to the shared data bus.
module tb_sram_ctrl;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic [ADDR_W-1:0] sram_addr;
  wire  [DATA_W-1:0] sram_data;
  logic              sram_ce_n;
  logic              sram_we_n;
  logic              sram_oe_n;

  logic [DATA_W-1:0] mem [0:63];
  logic [DATA_W-1:0] wbuf [0:7];

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int lastWrCyc = -100;

  logic [ADDR_W-1:0] wrAddrQ[$];
  logic [DATA_W-1:0] wrDataQ[$];
  int                wrCycQ[$];
  logic [ADDR_W-1:0] rdAddrQ[$];
  int                rdStbCycQ[$];
  logic [DATA_W-1:0] rspQ[$];
  int                rspCycQ[$];

  sram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  // Cycle n is the interval following the n-th rising edge.
  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural SRAM: writes land on the edge closing the strobe cycle,
  // reads drive the bus combinationally while ce_n/oe_n are low.
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) mem[sram_addr[5:0]] <= sram_data;
  end
  assign sram_data = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[5:0]] : {DATA_W{1'bz}};

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Bus monitor: records every strobe and response, and checks strobe
  // exclusivity and the write-to-read turnaround gap on every cycle.
  always @(negedge clk) begin
    checkOutput("strobe_excl", {63'd0, (!sram_we_n && !sram_oe_n)}, 64'd0);
    if (!sram_ce_n && !sram_we_n) begin
      wrAddrQ.push_back(sram_addr);
      wrDataQ.push_back(sram_data);
      wrCycQ.push_back(cycle);
      lastWrCyc = cycle;
    end
    if (!sram_ce_n && !sram_oe_n) begin
      rdAddrQ.push_back(sram_addr);
      rdStbCycQ.push_back(cycle);
      checkOutput("turnaround_gap", {63'd0, ((cycle - lastWrCyc) >= 2)}, 64'd1);
    end
    if (rsp_valid) begin
      rspQ.push_back(rsp_rdata);
      rspCycQ.push_back(cycle);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clearQueues();
    wrAddrQ.delete(); wrDataQ.delete(); wrCycQ.delete();
    rdAddrQ.delete(); rdStbCycQ.delete(); rspQ.delete(); rspCycQ.delete();
  endtask

  task automatic waitReady();
    int n = 0;
    while (!req_ready && n < 60) begin
      tick();
      n++;
    end
    checkOutput("req_ready_wait", {63'd0, req_ready}, 64'd1);
  endtask

  // Presents one request as soon as the controller is ready; e0 returns the
  // index of the accepting edge.
  task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [LEN_W-1:0] len, output int e0);
    waitReady();
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_len   = len;
    tick();
    e0 = cycle;
    req_valid = 1'b0;
    checkOutput("busy_after_accept", {63'd0, busy}, 64'd1);
    checkOutput("ready_after_accept", {63'd0, req_ready}, 64'd0);
  endtask

  task automatic writeData(input int len, input int gapAfter, input int gapLen);
    int i = 0;
    int gap = 0;
    int n = 0;
    logic acc;
    while (i <= len && n < 100) begin
      if (gap > 0) begin
        wdata_valid = 1'b0;
        gap--;
      end else begin
        wdata_valid = 1'b1;
        wdata = wbuf[i];
      end
      acc = wdata_valid && wdata_ready;
      tick();
      n++;
      if (acc) begin
        if (i == gapAfter) gap = gapLen;
        i++;
      end
    end
    wdata_valid = 1'b0;
    checkOutput("wdata_accept_count", i, len + 1);
  endtask

  task automatic waitRsp(input int count);
    int n = 0;
    while (rspQ.size() < count && n < 60) begin
      tick();
      n++;
    end
    checkOutput("rsp_count", rspQ.size(), count);
  endtask

  task automatic waitIdleAt(input int expCycle, input string tag);
    int n = 0;
    while (!req_ready && n < 60) begin
      tick();
      n++;
    end
    checkOutput(tag, cycle, expCycle);
  endtask

  initial begin
    int e0;
    int n;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wdata_valid = 1'b0; wdata = '0;
    tick(); tick();

    // Reset state
    checkOutput("rst_req_ready", {63'd0, req_ready}, 64'd0);
    checkOutput("rst_wdata_ready", {63'd0, wdata_ready}, 64'd0);
    checkOutput("rst_strobes", {61'd0, sram_ce_n, sram_we_n, sram_oe_n}, 64'd7);
    checkOutput("rst_addr", sram_addr, 0);
    checkOutput("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    tick();
    checkOutput("ready_after_rst", {63'd0, req_ready}, 64'd1);

    // Single write of 0xDEADBEEF at 0x10
    $display("[TB] single write");
    clearQueues();
    wbuf[0] = 32'hDEADBEEF;
    applyStimulus(1'b1, 23'h10, 8'd0, e0);
    writeData(0, -1, 0);
    waitIdleAt(e0 + 3, "wr1_ready_return");
    checkOutput("wr1_strobes", wrCycQ.size(), 1);
    checkOutput("wr1_cycle", wrCycQ[0], e0 + 1);
    checkOutput("wr1_addr", wrAddrQ[0], 23'h10);
    checkOutput("wr1_data", wrDataQ[0], 32'hDEADBEEF);

    // Read it back
    $display("[TB] single read");
    clearQueues();
    applyStimulus(1'b0, 23'h10, 8'd0, e0);
    waitRsp(1);
    checkOutput("rd1_strobe_cycle", rdStbCycQ[0], e0 + 1);
    checkOutput("rd1_addr", rdAddrQ[0], 23'h10);
    checkOutput("rd1_rsp_cycle", rspCycQ[0], e0 + 2);
    checkOutput("rd1_data", rspQ[0], 32'hDEADBEEF);
    tick();
    checkOutput("rd1_pulse_width", {63'd0, rsp_valid}, 64'd0);
    checkOutput("rd1_ready_return", {63'd0, req_ready}, 64'd1);

    // Four-word write with a two-cycle gap after the second word
    $display("[TB] burst write with stall");
    clearQueues();
    for (int i = 0; i < 4; i++) wbuf[i] = i + 1;
    applyStimulus(1'b1, 23'h20, 8'd3, e0);
    writeData(3, 1, 2);
    waitIdleAt(e0 + 8, "wr4_ready_return");
    checkOutput("wr4_strobes", wrCycQ.size(), 4);
    checkOutput("wr4_cycle1", wrCycQ[1], e0 + 2);
    checkOutput("wr4_cycle2", wrCycQ[2], e0 + 5);
    for (int i = 0; i < 4; i++) begin
      checkOutput("wr4_addr", wrAddrQ[i], 23'h20 + i);
      checkOutput("wr4_data", wrDataQ[i], i + 1);
    end

    // Four-word read of the same block
    $display("[TB] burst read");
    clearQueues();
    applyStimulus(1'b0, 23'h20, 8'd3, e0);
    waitRsp(4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("rd4_rsp_cycle", rspCycQ[i], e0 + 2 + i);
      checkOutput("rd4_data", rspQ[i], i + 1);
    end
    waitIdleAt(e0 + 6, "rd4_ready_return");

    // Address wrap, followed immediately by a read request
    $display("[TB] wrap write then read");
    clearQueues();
    wbuf[0] = 32'hA5A50001;
    wbuf[1] = 32'hA5A50002;
    applyStimulus(1'b1, 23'h7FFFFF, 8'd1, e0);
    writeData(1, -1, 0);
    checkOutput("wrap_wr_addr0", wrAddrQ[0], 23'h7FFFFF);
    checkOutput("wrap_wr_addr1", wrAddrQ[1], 23'h000000);
    applyStimulus(1'b0, 23'h7FFFFF, 8'd1, e0);
    waitRsp(2);
    checkOutput("wrap_rd_addr1", rdAddrQ[1], 23'h000000);
    checkOutput("wrap_rd_data0", rspQ[0], 32'hA5A50001);
    checkOutput("wrap_rd_data1", rspQ[1], 32'hA5A50002);
    checkOutput("wrap_gap", {63'd0, ((rdStbCycQ[0] - wrCycQ[1]) >= 2)}, 64'd1);

    // Reset in the middle of an eight-word read
    $display("[TB] reset mid read");
    tick(); tick();
    clearQueues();
    applyStimulus(1'b0, 23'h48, 8'd7, e0);
    n = 0;
    while (rdStbCycQ.size() < 4 && n < 60) begin
      tick();
      n++;
    end
    checkOutput("abort_strobe_count", rdStbCycQ.size(), 4);
    rst = 1'b1;
    tick();
    checkOutput("abort_strobes", {61'd0, sram_ce_n, sram_we_n, sram_oe_n}, 64'd7);
    checkOutput("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_req_ready", {63'd0, req_ready}, 64'd0);
    checkOutput("abort_rsp_rdata", rsp_rdata, 0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("abort_ready_after", {63'd0, req_ready}, 64'd1);
    tick(); tick(); tick();
    checkOutput("abort_rsp_total", rspQ.size(), 3);
    checkOutput("abort_strobe_total", rdStbCycQ.size(), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
